// File: rtl/rtl_settings_pkg.sv
// Shared AMM widths, compare-entry bundle and scheduler state type.
// Also holds the LFSR helper used to advance random data seeds.
package rtl_settings_pkg;

    localparam int AMM_ADDR_W    = 16;
    localparam int AMM_BURST_W   = 4;
    localparam int AMM_MAX_BURST = 1 << (AMM_BURST_W - 1);

    typedef enum logic {
        FIX_DATA = 1'b0,
        RND_DATA = 1'b1
    } data_mode_t;

    typedef struct packed {
        logic [AMM_ADDR_W-1:0]  start_addr;
        logic [AMM_BURST_W-1:0] words_count;
        logic [1:0]             start_off;
        logic [1:0]             end_off;
        logic [7:0]             data_ptrn;
        data_mode_t             data_mode;
    } cmp_struct_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ABORT
    } sched_state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

    // One LFSR step per word of the burst.
    function automatic logic [7:0] lfsr_adv(
        input logic [7:0]             p,
        input logic [AMM_BURST_W-1:0] n
    );
        logic [7:0] v;
        v = p;
        for (int i = 0; i < AMM_MAX_BURST; i++) begin
            if (i < int'(n)) v = lfsr_step(v);
        end
        return v;
    endfunction

endpackage

// File: rtl/outstanding_cnt.sv
// In-flight read word and compare-entry accounting.
// Entries retire when the last beat of the oldest burst returns.
module outstanding_cnt
    import rtl_settings_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CMP_DEPTH       = 4
) (
    input  logic                                 clk_i,
    input  logic                                 srst_n_i,
    input  logic                                 clr_i,
    input  logic                                 push_i,
    input  logic [AMM_BURST_W-1:0]               push_len_i,
    input  logic                                 beat_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] words_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] words_nxt_o,
    output logic [$clog2(CMP_DEPTH+1)-1:0]       entries_nxt_o
);

    localparam int WW = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW = $clog2(CMP_DEPTH + 1);
    localparam int PW = (CMP_DEPTH > 1) ? $clog2(CMP_DEPTH) : 1;

    logic [AMM_BURST_W-1:0] r_len [CMP_DEPTH];
    logic [PW-1:0]          r_wp;
    logic [PW-1:0]          r_rp;
    logic [WW-1:0]          r_words;
    logic [EW-1:0]          r_ent;
    logic [AMM_BURST_W-1:0] r_beat;

    logic          w_beat;
    logic          w_pop;
    logic [PW-1:0] w_wp_inc;
    logic [PW-1:0] w_rp_inc;

    // Beats with nothing in flight are dropped so the count cannot wrap.
    assign w_beat   = beat_i && (r_words != '0);
    assign w_pop    = w_beat
                   && ((r_beat + AMM_BURST_W'(1)) == r_len[r_rp]);
    assign w_wp_inc = (r_wp == PW'(CMP_DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_rp_inc = (r_rp == PW'(CMP_DEPTH - 1)) ? '0 : r_rp + PW'(1);

    assign words_nxt_o   = r_words
                         + (push_i ? WW'(push_len_i) : '0)
                         - (w_beat ? WW'(1) : '0);
    assign entries_nxt_o = r_ent + EW'(push_i) - EW'(w_pop);
    assign words_o       = r_words;

    always_ff @(posedge clk_i) begin
        if (push_i) r_len[r_wp] <= push_len_i;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i || clr_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_words <= '0;
            r_ent   <= '0;
            r_beat  <= '0;
        end else begin
            r_words <= words_nxt_o;
            r_ent   <= entries_nxt_o;
            if (push_i) r_wp <= w_wp_inc;
            if (w_pop) begin
                r_rp   <= w_rp_inc;
                r_beat <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + AMM_BURST_W'(1);
            end
        end
    end

endmodule

// File: rtl/rd_burst_sched.sv
// AMM read burst scheduler feeding compare entries.
// Define SCHED_STATS_EN to add bursts_o/stall_o statistics.
module rd_burst_sched
    import rtl_settings_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CMP_DEPTH       = 4
) (
    input  logic                   clk_i,
    input  logic                   srst_n_i,
    input  logic                   start_i,
    input  logic [AMM_ADDR_W-1:0]  base_addr_i,
    input  logic [31:0]            test_words_i,
    input  logic [AMM_BURST_W-1:0] burst_len_i,
    input  logic [7:0]             data_ptrn_i,
    input  data_mode_t             data_mode_i,
    output logic                   read_o,
    output logic [AMM_ADDR_W-1:0]  address_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    input  logic                   waitrequest_i,
    input  logic                   readdatavalid_i,
    output logic                   cmp_en_o,
    output cmp_struct_t            cmp_struct_o,
    input  logic                   cmp_busy_i,
    input  logic                   cmp_error_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]            bursts_o,
    output logic [31:0]            stall_o
`endif
);

    localparam int WW = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW = $clog2(CMP_DEPTH + 1);

    sched_state_t           r_state;
    logic                   r_read;
    logic [AMM_ADDR_W-1:0]  r_addr;
    logic [AMM_BURST_W-1:0] r_bcnt;
    logic [31:0]            r_rem;
    logic [AMM_BURST_W-1:0] r_blen;
    logic [7:0]             r_ptrn;
    data_mode_t             r_mode;
    logic                   r_done;
    logic                   r_err;

    logic                   w_start;
    logic                   w_accept;
    logic [WW-1:0]          w_words;
    logic [WW-1:0]          w_words_nxt;
    logic [EW-1:0]          w_ent_nxt;
    logic [AMM_ADDR_W-1:0]  w_addr_nxt;
    logic [31:0]            w_rem_nxt;
    logic [AMM_BURST_W-1:0] w_size;
    logic [7:0]             w_ptrn_nxt;
    logic                   w_fit;

    assign w_start  = (r_state == IDLE) && start_i;
    assign w_accept = r_read && !waitrequest_i;

    outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CMP_DEPTH      (CMP_DEPTH)
    ) u_cnt (
        .clk_i        (clk_i),
        .srst_n_i     (srst_n_i),
        .clr_i        (w_start),
        .push_i       (w_accept),
        .push_len_i   (r_bcnt),
        .beat_i       (readdatavalid_i),
        .words_o      (w_words),
        .words_nxt_o  (w_words_nxt),
        .entries_nxt_o(w_ent_nxt)
    );

    // Next command is sized against post-acceptance counts for back-to-back issue.
    assign w_addr_nxt = w_accept ? r_addr + AMM_ADDR_W'(r_bcnt) : r_addr;
    assign w_rem_nxt  = w_accept ? r_rem - 32'(r_bcnt) : r_rem;
    assign w_size     = (w_rem_nxt < 32'(r_blen))
                      ? w_rem_nxt[AMM_BURST_W-1:0] : r_blen;
    assign w_fit      = (32'(w_words_nxt) + 32'(w_size)
                         <= 32'(MAX_OUTSTANDING))
                     && (32'(w_ent_nxt) < 32'(CMP_DEPTH));
    assign w_ptrn_nxt = (w_accept && r_mode == RND_DATA)
                      ? lfsr_adv(r_ptrn, r_bcnt) : r_ptrn;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_addr  <= '0;
            r_bcnt  <= '0;
            r_rem   <= '0;
            r_blen  <= '0;
            r_ptrn  <= '0;
            r_mode  <= FIX_DATA;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_addr  <= base_addr_i;
                        r_rem   <= test_words_i;
                        r_blen  <= (burst_len_i == '0)
                                 ? AMM_BURST_W'(1) : burst_len_i;
                        r_ptrn  <= data_ptrn_i;
                        r_mode  <= data_mode_i;
                        r_err   <= 1'b0;
                        r_read  <= 1'b0;
                        r_state <= (test_words_i == 32'd0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmp_error_i) r_err <= 1'b1;
                    if (!(r_read && waitrequest_i)) begin
                        r_addr <= w_addr_nxt;
                        r_rem  <= w_rem_nxt;
                        r_ptrn <= w_ptrn_nxt;
                        if (r_err || cmp_error_i) begin
                            r_read  <= 1'b0;
                            r_state <= ABORT;
                        end else if (w_rem_nxt == 32'd0) begin
                            r_read  <= 1'b0;
                            r_state <= DRAIN;
                        end else begin
                            r_read <= w_fit;
                            r_bcnt <= w_size;
                        end
                    end
                end
                DRAIN: begin
                    if (w_words == '0 && !cmp_busy_i) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                ABORT: begin
                    if (w_words == '0) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign read_o       = r_read;
    assign address_o    = r_addr;
    assign burstcount_o = r_bcnt;
    assign cmp_en_o     = w_accept;
    assign busy_o       = (r_state != IDLE);
    assign done_o       = r_done;
    assign error_o      = r_err;

    assign cmp_struct_o.start_addr  = r_addr;
    assign cmp_struct_o.words_count = r_bcnt - AMM_BURST_W'(1);
    assign cmp_struct_o.start_off   = 2'd0;
    assign cmp_struct_o.end_off     = 2'd0;
    assign cmp_struct_o.data_ptrn   = r_ptrn;
    assign cmp_struct_o.data_mode   = r_mode;

`ifdef SCHED_STATS_EN
    logic [31:0] r_bursts;
    logic [31:0] r_stall;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i || w_start) begin
            r_bursts <= '0;
            r_stall  <= '0;
        end else begin
            if (w_accept && r_bursts != '1) r_bursts <= r_bursts + 32'd1;
            if (r_read && waitrequest_i && r_stall != '1)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign bursts_o = r_bursts;
    assign stall_o  = r_stall;
`endif

endmodule

// File: tb/tb_rd_burst_sched.sv
// Directed bench for rd_burst_sched; stats checks active when
// SCHED_STATS_EN is defined.
module tb_rd_burst_sched;
    import rtl_settings_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   srst_n_i = 1'b0;
    logic                   start_i = 1'b0;
    logic [AMM_ADDR_W-1:0]  base_addr_i = '0;
    logic [31:0]            test_words_i = '0;
    logic [AMM_BURST_W-1:0] burst_len_i = '0;
    logic [7:0]             data_ptrn_i = '0;
    data_mode_t             data_mode_i = FIX_DATA;
    logic                   read_o;
    logic [AMM_ADDR_W-1:0]  address_o;
    logic [AMM_BURST_W-1:0] burstcount_o;
    logic                   waitrequest_i = 1'b0;
    logic                   readdatavalid_i = 1'b0;
    logic                   cmp_en_o;
    cmp_struct_t            cmp_struct_o;
    logic                   cmp_busy_i = 1'b0;
    logic                   cmp_error_i = 1'b0;
    logic                   busy_o;
    logic                   done_o;
    logic                   error_o;
`ifdef SCHED_STATS_EN
    logic [31:0]            bursts_o;
    logic [31:0]            stall_o;
`endif

    rd_burst_sched #(
        .MAX_OUTSTANDING(8),
        .CMP_DEPTH      (4)
    ) dut (
        .clk_i          (clk),
        .srst_n_i       (srst_n_i),
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .test_words_i   (test_words_i),
        .burst_len_i    (burst_len_i),
        .data_ptrn_i    (data_ptrn_i),
        .data_mode_i    (data_mode_i),
        .read_o         (read_o),
        .address_o      (address_o),
        .burstcount_o   (burstcount_o),
        .waitrequest_i  (waitrequest_i),
        .readdatavalid_i(readdatavalid_i),
        .cmp_en_o       (cmp_en_o),
        .cmp_struct_o   (cmp_struct_o),
        .cmp_busy_i     (cmp_busy_i),
        .cmp_error_i    (cmp_error_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o)
`ifdef SCHED_STATS_EN
        ,
        .bursts_o       (bursts_o),
        .stall_o        (stall_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int ncmp = 0;
    int ndone = 0;
    int pending = 0;
    bit auto_ret = 1'b0;
    bit force_rdv = 1'b0;

    logic [AMM_ADDR_W-1:0]  q_addr [$];
    logic [AMM_BURST_W-1:0] q_bc [$];
    logic [AMM_BURST_W-1:0] q_wc [$];
    logic [7:0]             q_ptrn [$];

    logic [AMM_ADDR_W-1:0]  a0;
    logic [AMM_BURST_W-1:0] b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log this cycle's settled values, advance one clock, then drive beats.
    task automatic step();
        #1;
        if (read_o && !waitrequest_i) begin
            q_addr.push_back(address_o);
            q_bc.push_back(burstcount_o);
            q_wc.push_back(cmp_struct_o.words_count);
            q_ptrn.push_back(cmp_struct_o.data_ptrn);
            pending += int'(burstcount_o);
        end
        if (cmp_en_o) ncmp++;
        if (done_o) ndone++;
        @(posedge clk);
        @(negedge clk);
        if (auto_ret && pending > 0) begin
            readdatavalid_i = 1'b1;
            pending--;
        end else begin
            readdatavalid_i = force_rdv;
        end
    endtask

    task automatic start_test(input logic [AMM_ADDR_W-1:0] b,
                              input logic [31:0] w,
                              input logic [AMM_BURST_W-1:0] bl,
                              input logic [7:0] p,
                              input data_mode_t m);
        q_addr.delete();
        q_bc.delete();
        q_wc.delete();
        q_ptrn.delete();
        ncmp  = 0;
        ndone = 0;
        base_addr_i  = b;
        test_words_i = w;
        burst_len_i  = bl;
        data_ptrn_i  = p;
        data_mode_i  = m;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int k = 0;
        while (ndone == 0 && k < max) begin
            step();
            k++;
        end
        check(tag, 32'(ndone), 32'd1);
    endtask

    task automatic wait_cmds(input string tag, input int n, input int max);
        int k = 0;
        while (q_addr.size() < n && k < max) begin
            step();
            k++;
        end
        check(tag, 32'(q_addr.size()), 32'(n));
    endtask

    initial begin
        int k;

        step();
        step();
        check("rst_read", 32'(read_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_addr", 32'(address_o), 32'd0);
        srst_n_i = 1'b1;
        step();

        // Stray beats while idle must not disturb the word count.
        force_rdv = 1'b1;
        repeat (3) step();
        force_rdv = 1'b0;
        step();
        check("stray_busy", 32'(busy_o), 32'd0);

        // 20 words, burst 8, truncated last burst
        auto_ret = 1'b1;
        start_test(16'h100, 32'd20, 4'd8, 8'h5A, FIX_DATA);
        wait_done("b_done", 200);
        check("b_ncmds", 32'(q_addr.size()), 32'd3);
        check("b_addr0", 32'(q_addr[0]), 32'h100);
        check("b_addr1", 32'(q_addr[1]), 32'h108);
        check("b_addr2", 32'(q_addr[2]), 32'h110);
        check("b_bc0", 32'(q_bc[0]), 32'd8);
        check("b_bc2", 32'(q_bc[2]), 32'd4);
        check("b_wc0", 32'(q_wc[0]), 32'd7);
        check("b_wc1", 32'(q_wc[1]), 32'd7);
        check("b_wc2", 32'(q_wc[2]), 32'd3);
        check("b_ptrn", 32'(q_ptrn[2]), 32'h5A);
        check("b_cmpen", 32'(ncmp), 32'd3);
        check("b_error", 32'(error_o), 32'd0);
        check("b_busy", 32'(busy_o), 32'd0);
`ifdef SCHED_STATS_EN
        check("b_bursts", bursts_o, 32'd3);
        check("b_stall", stall_o, 32'd0);
`endif

        // Withheld data: second burst must wait for the first 8 beats
        auto_ret = 1'b0;
        start_test(16'h000, 32'd16, 4'd8, 8'h00, FIX_DATA);
        repeat (20) step();
        check("c_one_cmd", 32'(q_addr.size()), 32'd1);
        check("c_busy", 32'(busy_o), 32'd1);
        auto_ret = 1'b1;
        wait_done("c_done", 200);
        check("c_ncmds", 32'(q_addr.size()), 32'd2);
        check("c_addr1", 32'(q_addr[1]), 32'h008);

        // Five waitrequest cycles on the only command
        waitrequest_i = 1'b1;
        start_test(16'h040, 32'd4, 4'd4, 8'h11, FIX_DATA);
        k = 0;
        while (!read_o && k < 20) begin
            step();
            k++;
        end
        check("d_read_seen", 32'(read_o), 32'd1);
        a0 = address_o;
        b0 = burstcount_o;
        repeat (5) begin
            step();
            check("d_read_hold", 32'(read_o), 32'd1);
            check("d_addr_hold", 32'(address_o), 32'(a0));
            check("d_bc_hold", 32'(burstcount_o), 32'(b0));
        end
        waitrequest_i = 1'b0;
        wait_done("d_done", 100);
        check("d_cmpen", 32'(ncmp), 32'd1);
        check("d_addr", 32'(q_addr[0]), 32'h040);
        check("d_bc", 32'(q_bc[0]), 32'd4);
`ifdef SCHED_STATS_EN
        check("d_stall", stall_o, 32'd5);
        check("d_bursts", bursts_o, 32'd1);
`endif

        // Compare error after the 2nd of 4 bursts
        auto_ret = 1'b0;
        start_test(16'h200, 32'd16, 4'd4, 8'h00, FIX_DATA);
        wait_cmds("e_two_cmds", 2, 20);
        cmp_error_i = 1'b1;
        step();
        cmp_error_i = 1'b0;
        check("e_error", 32'(error_o), 32'd1);
        repeat (10) step();
        check("e_no_third", 32'(q_addr.size()), 32'd2);
        check("e_no_done", 32'(ndone), 32'd0);
        check("e_busy", 32'(busy_o), 32'd1);
        auto_ret = 1'b1;
        wait_done("e_done", 100);
        check("e_ncmds", 32'(q_addr.size()), 32'd2);
        check("e_sticky", 32'(error_o), 32'd1);

        // Random data seed progression
        start_test(16'h000, 32'd4, 4'd2, 8'h01, RND_DATA);
        wait_done("f_done", 100);
        check("f_ptrn0", 32'(q_ptrn[0]), 32'h01);
        check("f_ptrn1", 32'(q_ptrn[1]), 32'h06);
        check("f_wc1", 32'(q_wc[1]), 32'd1);
        check("f_addr1", 32'(q_addr[1]), 32'h002);
        check("f_error", 32'(error_o), 32'd0);

        // Reset mid-burst, then a fresh run that wraps the address
        auto_ret = 1'b0;
        start_test(16'h300, 32'd32, 4'd8, 8'h00, FIX_DATA);
        wait_cmds("g_first_cmd", 1, 20);
        srst_n_i = 1'b0;
        step();
        check("g_read", 32'(read_o), 32'd0);
        check("g_cmpen", 32'(cmp_en_o), 32'd0);
        check("g_done", 32'(done_o), 32'd0);
        check("g_error", 32'(error_o), 32'd0);
        check("g_busy", 32'(busy_o), 32'd0);
        check("g_addr", 32'(address_o), 32'd0);
        check("g_bc", 32'(burstcount_o), 32'd0);
        srst_n_i = 1'b1;
        pending  = 0;
        auto_ret = 1'b1;
        step();
        start_test(16'hFFFE, 32'd5, 4'd2, 8'h33, FIX_DATA);
        wait_done("g2_done", 100);
        check("g2_ncmds", 32'(q_addr.size()), 32'd3);
        check("g2_addr0", 32'(q_addr[0]), 32'hFFFE);
        check("g2_addr1", 32'(q_addr[1]), 32'h0000);
        check("g2_addr2", 32'(q_addr[2]), 32'h0002);
        check("g2_bc2", 32'(q_bc[2]), 32'd1);
        check("g2_error", 32'(error_o), 32'd0);

        // Zero words: done two cycles after start
        start_test(16'h500, 32'd0, 4'd4, 8'h00, FIX_DATA);
        check("h_busy", 32'(busy_o), 32'd1);
        check("h_done_early", 32'(done_o), 32'd0);
        step();
        check("h_done", 32'(done_o), 32'd1);
        check("h_idle", 32'(busy_o), 32'd0);
        check("h_ncmds", 32'(q_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
